// File: rtl/cmd_frame_wrapper_if.sv
// Bus between the copter UART transceiver, the frame wrapper and cmd_cfg.
// slave is the wrapper's view; master is the surrounding system's view.
interface cmd_frame_wrapper_if;
  logic        rx_rdy;
  logic [7:0]  rx_data;
  logic        clr_rx_rdy;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic [7:0]  resp;
  logic        send_resp;
  logic [7:0]  tx_data;
  logic        trmt;
  logic        tx_done;
  logic        resp_sent;
  logic        frame_err;

  modport slave (
    input  rx_rdy, rx_data, clr_cmd_rdy, resp, send_resp, tx_done,
    output clr_rx_rdy, cmd, data, cmd_rdy, tx_data, trmt, resp_sent, frame_err
  );

  modport master (
    output rx_rdy, rx_data, clr_cmd_rdy, resp, send_resp, tx_done,
    input  clr_rx_rdy, cmd, data, cmd_rdy, tx_data, trmt, resp_sent, frame_err
  );
endinterface

// File: rtl/cmd_frame_wrapper.sv
// Builds 3-byte wireless frames into cmd/data and returns single-byte
// responses to the UART transmitter through a 1-deep pending buffer.
//
// RX state | meaning
// ---------+--------------------------------------------
// RX_IDLE  | waiting for the command byte
// RX_HI    | command held, waiting for data high byte
// RX_LO    | data high held, waiting for data low byte
//
// TX state | meaning
// ---------+--------------------------------------------
// TX_IDLE  | transmitter free
// TX_BUSY  | byte in flight, waiting for tx_done
module cmd_frame_wrapper #(
  parameter int TIMEOUT_CYC = 65536,
  parameter int TMO_W       = 17
) (
  input logic clk,
  input logic rst_n,
  cmd_frame_wrapper_if.slave bus
);

  typedef enum logic [1:0] {RX_IDLE, RX_HI, RX_LO} rx_state_t;
  typedef enum logic       {TX_IDLE, TX_BUSY}      tx_state_t;

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  rx_state_t        rx_state_q, rx_state_d;
  logic [7:0]       shadow_cmd_q, shadow_cmd_d;
  logic [7:0]       shadow_hi_q, shadow_hi_d;
  logic [7:0]       cmd_q, cmd_d;
  logic [15:0]      data_q, data_d;
  logic             cmd_rdy_q, cmd_rdy_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             clr_rx_rdy, frame_err;

  tx_state_t        tx_state_q, tx_state_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             trmt_q, trmt_d;
  logic [7:0]       pending_q, pending_d;
  logic             pending_vld_q, pending_vld_d;
  logic             resp_sent;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_state_q    <= RX_IDLE;
      shadow_cmd_q  <= '0;
      shadow_hi_q   <= '0;
      cmd_q         <= '0;
      data_q        <= '0;
      cmd_rdy_q     <= 1'b0;
      tmo_cnt_q     <= '0;
      tx_state_q    <= TX_IDLE;
      tx_data_q     <= '0;
      trmt_q        <= 1'b0;
      pending_q     <= '0;
      pending_vld_q <= 1'b0;
    end else begin
      rx_state_q    <= rx_state_d;
      shadow_cmd_q  <= shadow_cmd_d;
      shadow_hi_q   <= shadow_hi_d;
      cmd_q         <= cmd_d;
      data_q        <= data_d;
      cmd_rdy_q     <= cmd_rdy_d;
      tmo_cnt_q     <= tmo_cnt_d;
      tx_state_q    <= tx_state_d;
      tx_data_q     <= tx_data_d;
      trmt_q        <= trmt_d;
      pending_q     <= pending_d;
      pending_vld_q <= pending_vld_d;
    end
  end

  // Strobes are gated by rst_n so a byte offered during reset is not acked.
  always_comb begin
    rx_state_d   = rx_state_q;
    shadow_cmd_d = shadow_cmd_q;
    shadow_hi_d  = shadow_hi_q;
    cmd_d        = cmd_q;
    data_d       = data_q;
    cmd_rdy_d    = cmd_rdy_q;
    tmo_cnt_d    = tmo_cnt_q;
    clr_rx_rdy   = 1'b0;
    frame_err    = 1'b0;

    if (bus.clr_cmd_rdy) cmd_rdy_d = 1'b0;

    case (rx_state_q)
      RX_IDLE: begin
        tmo_cnt_d = '0;
        if (bus.rx_rdy) begin
          clr_rx_rdy   = rst_n;
          shadow_cmd_d = bus.rx_data;
          cmd_rdy_d    = 1'b0;
          rx_state_d   = RX_HI;
        end
      end
      RX_HI, RX_LO: begin
        if (bus.rx_rdy) begin
          clr_rx_rdy = rst_n;
          tmo_cnt_d  = '0;
          if (rx_state_q == RX_HI) begin
            shadow_hi_d = bus.rx_data;
            rx_state_d  = RX_LO;
          end else begin
            cmd_d      = shadow_cmd_q;
            data_d     = {shadow_hi_q, bus.rx_data};
            cmd_rdy_d  = 1'b1;
            rx_state_d = RX_IDLE;
          end
        end else if (tmo_cnt_q == TMO_LAST) begin
          frame_err    = rst_n;
          shadow_cmd_d = '0;
          shadow_hi_d  = '0;
          tmo_cnt_d    = '0;
          rx_state_d   = RX_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // A response requested alongside tx_done is the newest, so it goes out next.
  always_comb begin
    tx_state_d    = tx_state_q;
    tx_data_d     = tx_data_q;
    trmt_d        = 1'b0;
    pending_d     = pending_q;
    pending_vld_d = pending_vld_q;
    resp_sent     = 1'b0;

    case (tx_state_q)
      TX_IDLE: begin
        if (bus.send_resp) begin
          tx_data_d  = bus.resp;
          trmt_d     = 1'b1;
          tx_state_d = TX_BUSY;
        end
      end
      TX_BUSY: begin
        if (bus.tx_done) begin
          resp_sent = rst_n;
          if (bus.send_resp) begin
            pending_d     = bus.resp;
            pending_vld_d = 1'b0;
            tx_data_d     = bus.resp;
            trmt_d        = 1'b1;
          end else if (pending_vld_q) begin
            pending_vld_d = 1'b0;
            tx_data_d     = pending_q;
            trmt_d        = 1'b1;
          end else begin
            tx_state_d = TX_IDLE;
          end
        end else if (bus.send_resp) begin
          pending_d     = bus.resp;
          pending_vld_d = 1'b1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  assign bus.clr_rx_rdy = clr_rx_rdy;
  assign bus.frame_err  = frame_err;
  assign bus.cmd        = cmd_q;
  assign bus.data       = data_q;
  assign bus.cmd_rdy    = cmd_rdy_q;
  assign bus.tx_data    = tx_data_q;
  assign bus.trmt       = trmt_q;
  assign bus.resp_sent  = resp_sent;

endmodule

// File: tb/tb_cmd_frame_wrapper.sv
// Directed bench for cmd_frame_wrapper with frame and response scoreboards;
// timeout shortened to 64 cycles so inter-byte gaps stay under 64.
module tb_cmd_frame_wrapper;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cmd_frame_wrapper_if bus();

  cmd_frame_wrapper #(.TIMEOUT_CYC(64), .TMO_W(7)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int checks = 0;
  int failures = 0;
  logic [23:0] frame_q[$];
  logic [7:0]  tx_q[$];
  int clr_cnt = 0, err_cnt = 0, sent_cnt = 0;
  logic rdy_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.cmd_rdy && !rdy_prev) begin
      if (frame_q.size() == 0) check("unexpected_frame", {8'h0, bus.cmd, bus.data}, 32'hFFFF_FFFF);
      else check("frame", {8'h0, bus.cmd, bus.data}, {8'h0, frame_q.pop_front()});
    end
    rdy_prev = bus.cmd_rdy;
    if (bus.trmt) begin
      if (tx_q.size() == 0) check("unexpected_trmt", {24'h0, bus.tx_data}, 32'hFFFF_FFFF);
      else check("tx_data", {24'h0, bus.tx_data}, {24'h0, tx_q.pop_front()});
    end
    if (bus.frame_err)  err_cnt++;
    if (bus.resp_sent)  sent_cnt++;
    if (bus.clr_rx_rdy) clr_cnt++;
  end

  task automatic send_byte(input logic [7:0] b, input logic clr = 1'b0);
    @(posedge clk); #1;
    bus.rx_rdy = 1'b1; bus.rx_data = b; bus.clr_cmd_rdy = clr;
    @(posedge clk); #1;
    bus.rx_rdy = 1'b0; bus.clr_cmd_rdy = 1'b0;
  endtask

  task automatic send_resp(input logic [7:0] r, input logic done = 1'b0);
    @(posedge clk); #1;
    bus.send_resp = 1'b1; bus.resp = r; bus.tx_done = done;
    @(posedge clk); #1;
    bus.send_resp = 1'b0; bus.tx_done = 1'b0;
  endtask

  task automatic pulse_done();
    @(posedge clk); #1; bus.tx_done = 1'b1;
    @(posedge clk); #1; bus.tx_done = 1'b0;
  endtask

  task automatic clear_rdy();
    @(posedge clk); #1; bus.clr_cmd_rdy = 1'b1;
    @(posedge clk); #1; bus.clr_cmd_rdy = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cmd"},     {24'h0, bus.cmd}, 32'h0);
    check({tag, "_data"},    {16'h0, bus.data}, 32'h0);
    check({tag, "_cmd_rdy"}, {31'h0, bus.cmd_rdy}, 32'h0);
    check({tag, "_tx_data"}, {24'h0, bus.tx_data}, 32'h0);
    check({tag, "_trmt"},    {31'h0, bus.trmt}, 32'h0);
    check({tag, "_strobes"}, {29'h0, bus.frame_err, bus.resp_sent, bus.clr_rx_rdy}, 32'h0);
  endtask

  initial begin
    bus.rx_rdy = 0; bus.rx_data = 0; bus.clr_cmd_rdy = 0;
    bus.resp = 0; bus.send_resp = 0; bus.tx_done = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Basic frame with wide gaps between bytes.
    send_byte(8'h08); repeat (40) @(posedge clk);
    send_byte(8'h04); repeat (40) @(posedge clk);
    frame_q.push_back({8'h08, 16'h0420});
    send_byte(8'h20);
    @(negedge clk);
    check("latency_cmd_rdy", {31'h0, bus.cmd_rdy}, 32'h1);
    check("clr_rx_cnt", clr_cnt, 3);
    check("no_err_basic", err_cnt, 0);

    // New frame without clearing: cmd_rdy drops, cmd/data hold.
    send_byte(8'h06);
    @(negedge clk);
    check("drop_on_byte1", {31'h0, bus.cmd_rdy}, 32'h0);
    check("hold_b1", {8'h0, bus.cmd, bus.data}, {8'h0, 8'h08, 16'h0420});
    send_byte(8'hF0);
    @(negedge clk);
    check("hold_b2", {8'h0, bus.cmd, bus.data}, {8'h0, 8'h08, 16'h0420});
    frame_q.push_back({8'h06, 16'hF0F0});
    send_byte(8'hF0);
    clear_rdy();
    @(negedge clk);
    check("clr_cmd_rdy", {31'h0, bus.cmd_rdy}, 32'h0);

    // Frame completes in the same cycle as clr_cmd_rdy: set wins.
    send_byte(8'h0A); send_byte(8'hBB);
    frame_q.push_back({8'h0A, 16'hBBCC});
    send_byte(8'hCC, 1'b1);
    @(negedge clk);
    check("set_wins", {31'h0, bus.cmd_rdy}, 32'h1);
    clear_rdy();

    // Timeout drops a partial frame exactly at count 63.
    send_byte(8'h02); send_byte(8'h12);
    repeat (62) @(posedge clk);
    @(negedge clk);
    check("no_err_early", {31'h0, bus.frame_err}, 32'h0);
    @(posedge clk); @(negedge clk);
    check("frame_err_pulse", {31'h0, bus.frame_err}, 32'h1);
    repeat (10) @(posedge clk);
    check("err_once", err_cnt, 1);
    check("tmo_keeps_rdy", {31'h0, bus.cmd_rdy}, 32'h0);
    send_byte(8'h05); send_byte(8'h00);
    frame_q.push_back({8'h05, 16'h0010});
    send_byte(8'h10);
    clear_rdy();

    // Third byte in the very cycle the timer reaches its limit.
    send_byte(8'h03); send_byte(8'h44);
    repeat (62) @(posedge clk);
    frame_q.push_back({8'h03, 16'h4455});
    send_byte(8'h55);
    repeat (70) @(posedge clk);
    check("byte_beats_tmo", err_cnt, 1);
    clear_rdy();

    // Response path: 3C overwritten by 77 while busy.
    tx_q.push_back(8'hA5); tx_q.push_back(8'h77);
    send_resp(8'hA5);
    repeat (3) @(posedge clk);
    send_resp(8'h3C);
    repeat (3) @(posedge clk);
    send_resp(8'h77);
    repeat (12) @(posedge clk);
    pulse_done();
    repeat (20) @(posedge clk);
    pulse_done();
    repeat (5) @(posedge clk);
    check("resp_sent_2", sent_cnt, 2);

    // send_resp together with tx_done goes straight out.
    tx_q.push_back(8'h11); tx_q.push_back(8'h22);
    send_resp(8'h11);
    repeat (5) @(posedge clk);
    send_resp(8'h22, 1'b1);
    repeat (5) @(posedge clk);
    pulse_done();
    repeat (5) @(posedge clk);

    // Reset in GET_LO and while BUSY with a pending byte.
    frame_q.push_back({8'h07, 16'h0102});
    send_byte(8'h07); send_byte(8'h01); send_byte(8'h02);
    send_byte(8'h09); send_byte(8'hAA);
    tx_q.push_back(8'h3C);
    send_resp(8'h3C);
    send_resp(8'h5A);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    check_all_zero("midop_reset");
    #1 rst_n = 1'b1;
    frame_q.push_back({8'h0B, 16'hCDEF});
    send_byte(8'h0B); send_byte(8'hCD); send_byte(8'hEF);
    tx_q.push_back(8'h66);
    send_resp(8'h66);
    repeat (5) @(posedge clk);
    pulse_done();
    repeat (5) @(posedge clk);
    pulse_done();
    repeat (10) @(posedge clk);

    check("frames_drained", frame_q.size(), 0);
    check("tx_drained", tx_q.size(), 0);
    check("resp_sent_total", sent_cnt, 5);
    check("err_total", err_cnt, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
